wr_arbiter: RTL and testbench

- Shares the single capture write controller between NUM_REQ packet FIFOs (for example, per-port capture queues).
- Selects requesters round-robin and pulses the writer's start input.
- Streams up to BURST_LEN words from the granted show-ahead FIFO, then waits for the writer's ready/completion before the next arbitration.
- Sits between the capture FIFOs and wr_ctrl in the tcpdump datapath.

---
 rtl/wr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wr_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_arbiter.sv
// rtl/wr_arbiter.sv - round-robin arbiter sharing one capture writer between packet FIFOs
// Optional per-requester word/grant counters: define WR_ARB_STATS_EN.
module wr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(BURST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        fifo_empty,
    input  logic [NUM_REQ*DATA_W-1:0] fifo_q,
    output logic [NUM_REQ-1:0]        fifo_rd,
    output logic                      wr_ctrl,
    input  logic                      wr_ctrl_rdy,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic                      wr_end,
    output logic [GW-1:0]             grant_id,
    output logic                      busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     word_cnt,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, ARB, START, XFER, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ctrl_q, wr_ctrl_d;
    logic          wr_end_q, wr_end_d;
    logic          busy_q, busy_d;

    logic          found;
    logic [GW-1:0] pick;
    logic [GW-1:0] cand;
    logic          gnt_empty;
    logic          in_xfer;
    logic          handshake;

    // Search starts just past the last completed grant, so the previous winner ranks last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign gnt_empty = fifo_empty[grant_q];
    assign in_xfer   = (state_q == XFER);
    // Gated by reset so no word is popped in the cycle the controller is being reset.
    assign wr_valid  = in_xfer && !gnt_empty && (count_q < CW'(BURST_LEN)) && !reset;
    assign handshake = wr_valid && wr_ready;
    assign fifo_rd   = handshake ? (NUM_REQ'(1) << grant_q) : '0;
    assign wr_data   = in_xfer ? fifo_q[int'(grant_q)*DATA_W +: DATA_W] : '0;
    assign wr_ctrl   = wr_ctrl_q;
    assign wr_end    = wr_end_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        count_d   = count_q;
        wr_ctrl_d = 1'b0;
        wr_end_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!(&fifo_empty)) state_d = ARB;
            end
            ARB: begin
                if (found) begin
                    grant_d   = pick;
                    state_d   = START;
                    wr_ctrl_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                count_d = '0;
                state_d = XFER;
            end
            XFER: begin
                if (handshake) count_d = count_q + CW'(1);
                if (gnt_empty || (handshake && count_q == CW'(BURST_LEN - 1))) begin
                    state_d  = WAIT_DONE;
                    wr_end_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (wr_ctrl_rdy) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            count_q   <= '0;
            wr_ctrl_q <= 1'b0;
            wr_end_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            count_q   <= count_d;
            wr_ctrl_q <= wr_ctrl_d;
            wr_end_q  <= wr_end_d;
            busy_q    <= busy_d;
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [NUM_REQ*32-1:0] word_cnt_q, word_cnt_d;
    logic [NUM_REQ*16-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        word_cnt_d  = word_cnt_q;
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fifo_rd[i]) word_cnt_d[i*32 +: 32] = word_cnt_q[i*32 +: 32] + 32'd1;
            if (state_q == START && grant_q == GW'(i))
                grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q  <= '0;
            grant_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_wr_arbiter.sv
// tb/tb_wr_arbiter.sv - randomized self-checking bench for wr_arbiter against a transaction-level model
module tb_wr_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int BL = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     fifo_empty;
    logic [NR*DW-1:0]  fifo_q;
    logic [NR-1:0]     fifo_rd;
    logic              wr_ctrl;
    logic              wr_ctrl_rdy;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_end;
    logic [0:0]        grant_id;
    logic              busy;
`ifdef WR_ARB_STATS_EN
    logic [NR*32-1:0]  word_cnt;
    logic [NR*16-1:0]  grant_cnt;
`endif

    wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
        .fifo_rd(fifo_rd), .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_end(wr_end), .grant_id(grant_id), .busy(busy)
`ifdef WR_ARB_STATS_EN
        , .word_cnt(word_cnt), .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string nm);
        checks++;
        fails++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", nm, cyc);
    endtask

    // Bench-side FIFOs feeding the DUT (show-ahead: head is visible before the pop).
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [DW-1:0] qhead(int i);
        if (i == 0) return (q0.size() > 0) ? q0[0] : '0;
        return (q1.size() > 0) ? q1[0] : '0;
    endfunction

    task automatic qpush(int i, logic [DW-1:0] v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    // Stimulus controls
    int ready_mode = 0;     // 0: always ready, 1: random, 2: 1,0,0,1 pattern from burst start
    bit rdy_rand   = 0;     // random wr_ctrl_rdy noise and random completion delay
    int rdy_delay  = 2;
    int rdy_wait   = 0;
    int xidx       = 0;
    bit pat[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [NR-1:0] pop_mask;

    task automatic drive();
        fifo_empty[0]   = (q0.size() == 0);
        fifo_empty[1]   = (q1.size() == 0);
        fifo_q[0 +: DW] = qhead(0);
        fifo_q[DW +: DW] = qhead(1);
        case (ready_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = ($urandom_range(0, 3) != 0);
            default: begin
                wr_ready = pat[xidx % 4];
                xidx++;
            end
        endcase
        if (rdy_wait > 0) begin
            rdy_wait--;
            wr_ctrl_rdy = (rdy_wait == 0);
        end else begin
            wr_ctrl_rdy = rdy_rand ? ($urandom_range(0, 5) == 0) : 1'b0;
        end
    endtask

    initial begin : driver
        pop_mask = '0;
        drive();
        forever begin
            @(negedge clk);
            pop_mask = fifo_rd;
            if (wr_end) rdy_wait = rdy_rand ? $urandom_range(1, 4) : rdy_delay;
            if (wr_ctrl) xidx = 0;
            @(posedge clk);
            cyc++;
            #1;
            if (pop_mask[0] && q0.size() > 0) void'(q0.pop_front());
            if (pop_mask[1] && q1.size() > 0) void'(q1.pop_front());
            drive();
        end
    end

    // Transaction-level reference: one grant = idle wait, one arbitration cycle,
    // one start cycle, a burst of words, then a wait for the writer's completion.
    bit            model_en = 0;
    int            m_last;
    int            m_gid;
    int            g_log[$];
    int            s_log[$];
    logic [DW-1:0] w_log[$];

    task automatic m_tick(output bit ab);
        @(negedge clk);
        ab = !model_en;
    endtask

    task automatic chk_quiet(bit bsy, bit ctrl, bit endp);
        chk("busy", busy, bsy);
        chk("wr_ctrl", wr_ctrl, ctrl);
        chk("wr_end", wr_end, endp);
        chk("wr_valid", wr_valid, 0);
        chk("fifo_rd", fifo_rd, 0);
        chk("grant_id", grant_id, m_gid);
    endtask

    task automatic model_txn();
        bit ab;
        bit v;
        bit first;
        int g;
        int n;
        forever begin
            m_tick(ab);
            if (ab) return;
            chk_quiet(0, 0, 0);
            if (fifo_empty != '1) break;
        end
        m_tick(ab);
        if (ab) return;
        chk_quiet(1, 0, 0);
        g = -1;
        for (int k = 1; k <= NR; k++)
            if (g < 0 && !fifo_empty[(m_last + k) % NR]) g = (m_last + k) % NR;
        if (g < 0) return;
        m_gid = g;
        m_tick(ab);
        if (ab) return;
        chk_quiet(1, 1, 0);
        n = 0;
        forever begin
            m_tick(ab);
            if (ab) return;
            v = !fifo_empty[m_gid] && (n < BL);
            chk("busy", busy, 1);
            chk("wr_ctrl", wr_ctrl, 0);
            chk("wr_end", wr_end, 0);
            chk("grant_id", grant_id, m_gid);
            chk("wr_valid", wr_valid, v);
            if (v) chk("wr_data", wr_data, qhead(m_gid));
            chk("fifo_rd", fifo_rd, (v && wr_ready) ? (64'd1 << m_gid) : 64'd0);
            if (v && wr_ready) begin
                n++;
                w_log.push_back(qhead(m_gid));
            end
            if (fifo_empty[m_gid] || n == BL) break;
        end
        first = 1;
        forever begin
            m_tick(ab);
            if (ab) return;
            chk_quiet(1, 0, first);
            first = 0;
            if (wr_ctrl_rdy) break;
        end
        m_last = m_gid;
        g_log.push_back(m_gid);
        s_log.push_back(n);
    endtask

    initial begin : model
        forever begin
            wait (model_en);
            m_last = NR - 1;
            m_gid  = 0;
            while (model_en) model_txn();
        end
    end

    task automatic clear_logs();
        g_log.delete();
        s_log.delete();
        w_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        q0.delete();
        q1.delete();
        #2;
        model_en = 0;
        reset    = 1;
        rdy_wait = 0;
        repeat (2) @(posedge clk);
        #2;
        reset    = 0;
        model_en = 1;
        clear_logs();
    endtask

    task automatic wait_quiet(string nm);
        int quiet = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy) quiet++; else quiet = 0;
            if (quiet >= 3) return;
        end
        fail_now(nm);
    endtask

    task automatic wait_ctrl(string nm, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_ctrl) begin
                ok = 1;
                return;
            end
        end
        fail_now(nm);
    endtask

    task automatic chk_logs(string nm, int eg[$], int es[$]);
        chk({nm, "_grants"}, g_log.size(), eg.size());
        for (int i = 0; i < eg.size() && i < g_log.size(); i++) begin
            chk({nm, "_gid"}, g_log[i], eg[i]);
            chk({nm, "_size"}, s_log[i], es[i]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : test
        bit ok;
        int k;
        int pops;
        int pushed;
        int sum;
        logic [DW-1:0] seen[4];

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ctrl", wr_ctrl, 0);
        chk("rst_wr_end", wr_end, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_grant_id", grant_id, 0);
        @(posedge clk);
        #2;
        reset    = 0;
        model_en = 1;

        // Three words in FIFO0, start latency and completion wait
        rdy_delay = 3;
        repeat (2) @(posedge clk);
        q0.push_back(32'hA1);
        q0.push_back(32'hA2);
        q0.push_back(32'hA3);
        #2;
        k = cyc;
        wait_ctrl("t1_ctrl", ok);
        if (ok) chk("t1_ctrl_latency", cyc - k, 2);
        wait_quiet("t1_quiet");
        chk_logs("t1", '{0}, '{3});
        chk("t1_words", w_log.size(), 3);
        if (w_log.size() == 3) begin
            chk("t1_w0", w_log[0], 32'hA1);
            chk("t1_w1", w_log[1], 32'hA2);
            chk("t1_w2", w_log[2], 32'hA3);
        end
        chk("t1_busy_end", busy, 0);

        // 40 words in each FIFO, completion two cycles after wr_end
        rdy_delay = 2;
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            q0.push_back(32'h1000_0000 + i);
            q1.push_back(32'h2000_0000 + i);
        end
        wait_quiet("t2_quiet");
        chk_logs("t2", '{0, 1, 0, 1, 0, 1}, '{16, 16, 16, 16, 8, 8});
`ifdef WR_ARB_STATS_EN
        chk("t2_word_cnt0", word_cnt[31:0], 40);
        chk("t2_word_cnt1", word_cnt[63:32], 40);
        chk("t2_grant_cnt0", grant_cnt[15:0], 3);
        chk("t2_grant_cnt1", grant_cnt[31:16], 3);
`endif

        // Ready pattern 1,0,0,1 at the start of the burst
        do_reset();
        ready_mode = 2;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) q0.push_back(32'h3000_0000 + i);
        wait_ctrl("t3_ctrl", ok);
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[i] = wr_data;
            if (fifo_rd[0]) pops++;
        end
        chk("t3_pops", pops, 2);
        chk("t3_d0", seen[0], 32'h3000_0001);
        chk("t3_d1", seen[1], 32'h3000_0002);
        chk("t3_d2", seen[2], 32'h3000_0002);
        chk("t3_d3", seen[3], 32'h3000_0002);
        wait_quiet("t3_quiet");
        chk_logs("t3", '{0}, '{8});
        for (int i = 0; i < w_log.size(); i++) chk("t3_seq", w_log[i], 32'h3000_0001 + i);
        ready_mode = 0;

        // FIFO1 runs dry after 5 words; FIFO0 fills during that grant
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 5; i++) q1.push_back(32'h4000_0000 + i);
        wait_ctrl("t4_ctrl", ok);
        @(posedge clk);
        for (int i = 0; i < 10; i++) q0.push_back(32'h5000_0000 + i);
        wait_quiet("t4_quiet");
        chk_logs("t4", '{1, 0}, '{5, 10});

        // Reset in the middle of requester 1's burst after 7 words
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 3; i++) q0.push_back(32'h6000_0000 + i);
        for (int i = 0; i < 20; i++) q1.push_back(32'h7000_0000 + i);
        pops = 0;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (fifo_rd[1]) pops++;
            if (pops == 7) ok = 1;
        end
        if (!ok) fail_now("t5_seven_pops");
        @(posedge clk);
        for (int i = 0; i < 4; i++) q0.push_back(32'h8000_0000 + i);
        #2;
        model_en = 0;
        reset    = 1;
        @(negedge clk);
        chk("t5_rst_fifo_rd", fifo_rd, 0);
        @(posedge clk);
        #2;
        reset    = 0;
        model_en = 1;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_wr_ctrl", wr_ctrl, 0);
        chk("t5_wr_valid", wr_valid, 0);
        chk("t5_wr_end", wr_end, 0);
        chk("t5_fifo_rd", fifo_rd, 0);
        chk("t5_grant_id", grant_id, 0);
        wait_quiet("t5_quiet");
        chk_logs("t5", '{0, 0, 1}, '{3, 4, 13});

        // Randomized traffic, stalls and completion timing
        do_reset();
        ready_mode = 1;
        rdy_rand   = 1;
        pushed     = 0;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            for (int i = 0; i < NR; i++)
                if ($urandom_range(0, 3) == 0 && qsize(i) < 40) begin
                    qpush(i, $urandom);
                    pushed++;
                end
        end
        wait_quiet("rand_quiet");
        sum = 0;
        foreach (s_log[i]) sum += s_log[i];
        chk("rand_words_served", sum, pushed);
        ready_mode = 0;
        rdy_rand   = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
